div_issue_8: RTL

- Request scheduler that sits directly upstream of the 8-bit signed iterative divider (divs_8).
- Buffers tagged divide requests in a small FIFO and issues them one at a time with a one-cycle start pulse.
- Waits for the divider's done pulse, then returns quotient, remainder and tag on a valid/ready result port.
- Bypasses the divider for divide-by-zero (which would never terminate in the divider) and for the -128/-1 overflow case.

---
 rtl/div_pkg.sv | 36 +++
 rtl/div_req_fifo.sv | 51 +++++
 rtl/div_issue_8.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divide request scheduler.
//   DATA_W              operand / result width
//   ST_OK/ST_DZ/ST_OVF  result status codes
//   div_state_t         scheduler FSM states
//   MIN_NEG/NEG_ONE     operands of the one signed overflow case
//   classify()          decides whether a request can bypass the divider
package div_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DZ  = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;

    localparam logic [DATA_W-1:0] MIN_NEG  = 8'h80;
    localparam logic [DATA_W-1:0] NEG_ONE  = 8'hFF;
    localparam logic [DATA_W-1:0] ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } div_state_t;

    // Divide-by-zero would never terminate in the divider, and -128/-1 has no
    // representable quotient, so both are answered without starting it.
    function automatic logic [1:0] classify(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        if (b == '0)
            return ST_DZ;
        if (a == MIN_NEG && b == NEG_ONE)
            return ST_OVF;
        return ST_OK;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous show-ahead FIFO holding tagged divide requests.
//   clk, rst    clock, synchronous active-high reset
//   push, din   write request and data (ignored when full)
//   pop         read request (ignored when empty)
//   dout        head entry, valid combinationally while !empty
//   full/empty  occupancy flags
module div_req_fifo
    import div_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/div_issue_8.sv
// Request scheduler in front of the 8-bit signed iterative divider.
//   req_valid/req_ready/req_a/req_b/req_tag   tagged request input (FIFO push)
//   div_start/div_src1/div_src2               one-cycle start and operands to divider
//   div_q/div_r/div_done                      divider result and completion pulse
//   res_valid/res_ready/res_q/res_r/res_tag/res_status   result output
//   busy                                      FSM active or requests queued
//
// state  | meaning
// S_IDLE | no divide outstanding; pops the FIFO head when one is present
// S_WAIT | divider started, waiting for div_done
// S_OUT  | result held on res_* until res_ready
module div_issue_8
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_a,
    input  logic [7:0]        req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              div_start,
    output logic [7:0]        div_src1,
    output logic [7:0]        div_src2,
    input  logic [7:0]        div_q,
    input  logic [7:0]        div_r,
    input  logic              div_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_q,
    output logic [7:0]        res_r,
    output logic [TAG_W-1:0]  res_tag,
    output logic [1:0]        res_status,
    output logic              busy
);

    localparam int ENT_W = 2*DATA_W + TAG_W;

    div_state_t        state;
    div_state_t        state_nxt;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  fifo_din;
    logic [ENT_W-1:0]  fifo_dout;
    logic [7:0]        head_a;
    logic [7:0]        head_b;
    logic [TAG_W-1:0]  head_tag;
    logic [1:0]        head_class;
    logic [TAG_W-1:0]  tag_q;

    // req_ready deliberately ignores a same-cycle pop.
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign fifo_din   = {req_tag, req_a, req_b};
    assign {head_tag, head_a, head_b} = fifo_dout;
    assign head_class = classify(head_a, head_b);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    div_req_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty)
                    state_nxt = (head_class == ST_OK) ? S_WAIT : S_OUT;
            end
            S_WAIT: begin
                if (div_done)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                if (res_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_start  <= 1'b0;
            div_src1   <= '0;
            div_src2   <= '0;
            res_valid  <= 1'b0;
            res_q      <= '0;
            res_r      <= '0;
            res_tag    <= '0;
            res_status <= ST_OK;
            tag_q      <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        case (head_class)
                            ST_DZ: begin
                                // Quotient of all ones, remainder is the dividend.
                                res_q      <= ALL_ONES;
                                res_r      <= head_a;
                                res_status <= ST_DZ;
                                res_tag    <= head_tag;
                                res_valid  <= 1'b1;
                            end
                            ST_OVF: begin
                                // -128/-1 wraps back to -128 with no remainder.
                                res_q      <= MIN_NEG;
                                res_r      <= '0;
                                res_status <= ST_OVF;
                                res_tag    <= head_tag;
                                res_valid  <= 1'b1;
                            end
                            default: begin
                                div_src1  <= head_a;
                                div_src2  <= head_b;
                                div_start <= 1'b1;
                                tag_q     <= head_tag;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (div_done) begin
                        res_q      <= div_q;
                        res_r      <= div_r;
                        res_status <= ST_OK;
                        res_tag    <= tag_q;
                        res_valid  <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready)
                        res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
